// File: rtl/laser_cover_gen.sv
// laser_cover_gen: two-circle coverage search over a 2^COORD_W square grid.
// Points are streamed in, then alternating coordinate-descent phases pick the
// raster-first grid centre maximising cover while the other centre is held.
module laser_cover_gen #(
  parameter int COORD_W  = 4,
  parameter int NUM_PTS  = 40,
  parameter int RADIUS   = 4,
  parameter int MAX_ITER = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         IN_VALID,
  input  logic [COORD_W-1:0]           X,
  input  logic [COORD_W-1:0]           Y,
  output logic [COORD_W-1:0]           C1X,
  output logic [COORD_W-1:0]           C1Y,
  output logic [COORD_W-1:0]           C2X,
  output logic [COORD_W-1:0]           C2Y,
  output logic [$clog2(NUM_PTS+1)-1:0] COVER,
  output logic                         DONE
);

  localparam int IDX_W = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
  localparam int CNT_W = $clog2(NUM_PTS + 1);
  localparam int IT_W  = $clog2(MAX_ITER + 1);
  localparam int SQ_W  = 2 * COORD_W + 1;
  localparam logic [SQ_W-1:0]  R2       = SQ_W'(RADIUS * RADIUS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);

  typedef enum logic [1:0] {LOAD, SCAN_A, SCAN_B, CHECK} state_t;

  state_t state, state_nx;

  logic [COORD_W-1:0] pts_x [NUM_PTS];
  logic [COORD_W-1:0] pts_y [NUM_PTS];

  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] cx, cy;
  logic [CNT_W-1:0]   acc, best, it_cover, prev_cover;
  logic [COORD_W-1:0] bpx, bpy;
  logic [COORD_W-1:0] wc1x, wc1y, wc2x, wc2y;
  logic [IT_W-1:0]    iter;

  logic [COORD_W-1:0] px, py, fx, fy;
  logic               hit, better, last_pt, last_cand, converged;
  logic [CNT_W-1:0]   acc_nx;

  // Full-precision squared distance, no truncation before the compare.
  function automatic logic in_rad(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                  input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    logic [COORD_W-1:0] dx, dy;
    logic [SQ_W-1:0]    d2;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    d2 = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
    return d2 <= R2;
  endfunction

  // Per-cycle evaluation of one point against the candidate and the held centre.
  always_comb begin
    px        = pts_x[idx];
    py        = pts_y[idx];
    fx        = (state == SCAN_A) ? wc2x : wc1x;
    fy        = (state == SCAN_A) ? wc2y : wc1y;
    hit       = in_rad(cx, cy, px, py) | in_rad(fx, fy, px, py);
    acc_nx    = acc + CNT_W'(hit);
    better    = acc_nx > best;
    last_pt   = (idx == LAST_IDX);
    last_cand = (&cx) & (&cy);
    converged = (it_cover == prev_cover) || (iter == IT_W'(MAX_ITER));
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= LOAD;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (IN_VALID && last_pt) state_nx = SCAN_A;
      SCAN_A:  if (last_pt && last_cand) state_nx = SCAN_B;
      SCAN_B:  if (last_pt && last_cand) state_nx = CHECK;
      CHECK:   state_nx = converged ? LOAD : SCAN_A;
      default: state_nx = LOAD;
    endcase
  end

  // Point store; contents are only meaningful after a complete load.
  always_ff @(posedge CLK) begin
    if (state == LOAD && IN_VALID) begin
      pts_x[idx] <= X;
      pts_y[idx] <= Y;
    end
  end

  // Search datapath and result registers.
  // Phase-end centre update folds in the last candidate's own compare,
  // since bestpos would otherwise only settle one cycle too late.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx        <= '0;
      cx         <= '0;
      cy         <= '0;
      acc        <= '0;
      best       <= '0;
      bpx        <= '0;
      bpy        <= '0;
      wc1x       <= '0;
      wc1y       <= '0;
      wc2x       <= '0;
      wc2y       <= '0;
      it_cover   <= '0;
      prev_cover <= '0;
      iter       <= '0;
      C1X        <= '0;
      C1Y        <= '0;
      C2X        <= '0;
      C2Y        <= '0;
      COVER      <= '0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        LOAD: begin
          if (IN_VALID) begin
            if (last_pt) begin
              idx        <= '0;
              cx         <= '0;
              cy         <= '0;
              acc        <= '0;
              best       <= '0;
              bpx        <= wc1x;
              bpy        <= wc1y;
              prev_cover <= '0;
              iter       <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        SCAN_A, SCAN_B: begin
          if (last_pt) begin
            idx <= '0;
            acc <= '0;
            cx  <= cx + COORD_W'(1);
            if (&cx) cy <= cy + COORD_W'(1);
            if (better) begin
              best <= acc_nx;
              bpx  <= cx;
              bpy  <= cy;
            end
            if (last_cand) begin
              best <= '0;
              if (state == SCAN_A) begin
                wc1x <= better ? cx : bpx;
                wc1y <= better ? cy : bpy;
                bpx  <= wc2x;
                bpy  <= wc2y;
              end else begin
                wc2x     <= better ? cx : bpx;
                wc2y     <= better ? cy : bpy;
                it_cover <= better ? acc_nx : best;
                iter     <= iter + IT_W'(1);
              end
            end
          end else begin
            idx <= idx + IDX_W'(1);
            acc <= acc_nx;
          end
        end
        CHECK: begin
          if (converged) begin
            C1X   <= wc1x;
            C1Y   <= wc1y;
            C2X   <= wc2x;
            C2Y   <= wc2y;
            COVER <= it_cover;
            DONE  <= 1'b1;
            idx   <= '0;
          end else begin
            prev_cover <= it_cover;
            best       <= '0;
            bpx        <= wc1x;
            bpy        <= wc1y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_cover_gen.sv
// tb_laser_cover_gen: randomized and directed patterns on a reduced grid,
// checked against a loop-based reference of the coordinate-descent search.
module tb_laser_cover_gen;

  localparam int CW     = 3;
  localparam int NP     = 8;
  localparam int RAD    = 2;
  localparam int MI     = 3;
  localparam int GRID   = 1 << CW;
  localparam int P      = GRID * GRID * NP;
  localparam int IT_CYC = 2 * P + 1;
  localparam int OW     = $clog2(NP + 1);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [CW-1:0] X = '0, Y = '0;
  logic [CW-1:0] C1X, C1Y, C2X, C2Y;
  logic [OW-1:0] COVER;
  logic          DONE;

  laser_cover_gen #(
    .COORD_W (CW),
    .NUM_PTS (NP),
    .RADIUS  (RAD),
    .MAX_ITER(MI)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .IN_VALID(IN_VALID),
    .X       (X),
    .Y       (Y),
    .C1X     (C1X),
    .C1Y     (C1Y),
    .C2X     (C2X),
    .C2Y     (C2Y),
    .COVER   (COVER),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  int px [NP];
  int py [NP];

  // Reference working centres and last reported result.
  int m_w1x = 0, m_w1y = 0, m_w2x = 0, m_w2y = 0;
  int r_c1x = 0, r_c1y = 0, r_c2x = 0, r_c2y = 0, r_cov = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit covers(input int ax, input int ay, input int bx, input int by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by) <= RAD * RAD;
  endfunction

  function automatic int count_cov(input int cx, input int cy, input int fx, input int fy);
    int n = 0;
    for (int i = 0; i < NP; i++)
      if (covers(cx, cy, px[i], py[i]) || covers(fx, fy, px[i], py[i])) n++;
    return n;
  endfunction

  task automatic model_run(output int e1x, output int e1y, output int e2x, output int e2y,
                           output int ecov, output int eit);
    int prev = 0, cov = 0, it = 0, best, bx, by, n;
    bit fin;
    do begin
      best = 0; bx = m_w1x; by = m_w1y;
      for (int cy = 0; cy < GRID; cy++)
        for (int cx = 0; cx < GRID; cx++) begin
          n = count_cov(cx, cy, m_w2x, m_w2y);
          if (n > best) begin best = n; bx = cx; by = cy; end
        end
      m_w1x = bx; m_w1y = by;
      best = 0; bx = m_w2x; by = m_w2y;
      for (int cy = 0; cy < GRID; cy++)
        for (int cx = 0; cx < GRID; cx++) begin
          n = count_cov(cx, cy, m_w1x, m_w1y);
          if (n > best) begin best = n; bx = cx; by = cy; end
        end
      m_w2x = bx; m_w2y = by;
      cov = best;
      it++;
      fin = (cov == prev) || (it == MI);
      prev = cov;
    end while (!fin);
    e1x = m_w1x; e1y = m_w1y; e2x = m_w2x; e2y = m_w2y; ecov = cov; eit = it;
  endtask

  // Called #1 after an edge; returns #1 after the edge accepting the last point.
  task automatic load_pts(input bit gaps);
    for (int i = 0; i < NP; i++) begin
      if (gaps && (i % 2 == 1 || $urandom_range(0, 1) == 1)) begin
        IN_VALID = 1'b0;
        X = CW'($urandom);
        Y = CW'($urandom);
        @(posedge CLK); #1;
      end
      IN_VALID = 1'b1;
      X = CW'(px[i]);
      Y = CW'(py[i]);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic run_and_check(input string name, input bit gaps, input bit chain, output int k);
    int e1x, e1y, e2x, e2y, ecov, eit;
    bit seen;
    model_run(e1x, e1y, e2x, e2y, ecov, eit);
    load_pts(gaps);
    seen = 1'b0;
    k = 0;
    while (!seen && k < MI * IT_CYC + 20) begin
      @(posedge CLK); #1;
      k++;
      if (k == 1) begin
        check({name, "_hold_c1x"}, int'(C1X), r_c1x);
        check({name, "_hold_c1y"}, int'(C1Y), r_c1y);
        check({name, "_hold_c2x"}, int'(C2X), r_c2x);
        check({name, "_hold_c2y"}, int'(C2Y), r_c2y);
        check({name, "_hold_cov"}, int'(COVER), r_cov);
      end
      seen = DONE;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    check({name, "_done_cycle"}, k, eit * IT_CYC);
    check({name, "_c1x"}, int'(C1X), e1x);
    check({name, "_c1y"}, int'(C1Y), e1y);
    check({name, "_c2x"}, int'(C2X), e2x);
    check({name, "_c2y"}, int'(C2Y), e2y);
    check({name, "_cover"}, int'(COVER), ecov);
    r_c1x = e1x; r_c1y = e1y; r_c2x = e2x; r_c2y = e2y; r_cov = ecov;
    if (!chain) begin
      @(posedge CLK); #1;
      check({name, "_done_pulse"}, int'(DONE), 0);
    end
  endtask

  task automatic set_clusters();
    for (int i = 0; i < NP; i++) begin
      px[i] = (i < NP / 2) ? 1 : 6;
      py[i] = px[i];
    end
  endtask

  task automatic check_const_result(input string name, input int k);
    check({name, "_k_const"}, k, 2050);
    check({name, "_c1x_const"}, int'(C1X), 6);
    check({name, "_c1y_const"}, int'(C1Y), 4);
    check({name, "_c2x_const"}, int'(C2X), 0);
    check({name, "_c2y_const"}, int'(C2Y), 0);
    check({name, "_cov_const"}, int'(COVER), 8);
  endtask

  initial begin
    int k;
    bit stray;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_c1x", int'(C1X), 0);
    check("rst_c2y", int'(C2Y), 0);
    check("rst_cover", int'(COVER), 0);
    check("rst_done", int'(DONE), 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Two clusters on the reduced grid
    set_clusters();
    run_and_check("clusters", 1'b0, 1'b0, k);
    check_const_result("clusters", k);

    // Random pattern with gaps, then a chained single cluster in the DONE cycle
    for (int i = 0; i < NP; i++) begin
      px[i] = $urandom_range(0, GRID - 1);
      py[i] = $urandom_range(0, GRID - 1);
    end
    run_and_check("rand_pre_b2b", 1'b1, 1'b1, k);
    for (int i = 0; i < NP; i++) begin
      px[i] = 7;
      py[i] = 7;
    end
    run_and_check("b2b_corner", 1'b0, 1'b0, k);

    // Randomized patterns, random gaps and chaining
    for (int t = 0; t < 8; t++) begin
      int cxr = $urandom_range(0, GRID - 1);
      int cyr = $urandom_range(0, GRID - 1);
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          px[i] = (cxr + $urandom_range(0, 2)) % GRID;
          py[i] = (cyr + $urandom_range(0, 2)) % GRID;
        end else begin
          px[i] = $urandom_range(0, GRID - 1);
          py[i] = $urandom_range(0, GRID - 1);
        end
      end
      run_and_check($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), k);
    end

    // Reset in the middle of a scan
    set_clusters();
    load_pts(1'b0);
    stray = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge CLK); #1;
      if (DONE) stray = 1'b1;
    end
    check("midscan_no_done", int'(stray), 0);
    #3 RST_N = 1'b0;
    #1;
    check("midrst_c1x", int'(C1X), 0);
    check("midrst_c1y", int'(C1Y), 0);
    check("midrst_c2x", int'(C2X), 0);
    check("midrst_cover", int'(COVER), 0);
    check("midrst_done", int'(DONE), 0);
    m_w1x = 0; m_w1y = 0; m_w2x = 0; m_w2y = 0;
    r_c1x = 0; r_c1y = 0; r_c2x = 0; r_c2y = 0; r_cov = 0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    run_and_check("after_rst", 1'b1, 1'b0, k);
    check_const_result("after_rst", k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_cover_gen.md
# laser_cover_gen

Parametrised two-circle coverage engine, successor to the fixed 16x16 / 40-point LASER core. It accepts NUM_PTS points on a 2^COORD_W x 2^COORD_W grid and finds two centres C1 and C2 so that as many points as possible lie within RADIUS of at least one centre. The search is iterative coordinate descent over every grid candidate, and the block reports the achieved cover count. It sits behind the same point-streaming front end as LASER and handles back-to-back patterns without reset.

## Interface
- COORD_W, 4, coordinate width; the grid is 2^COORD_W per axis.
- NUM_PTS, 40, number of points per pattern.
- RADIUS, 4, cover radius; a point is covered when dx²+dy² <= RADIUS².
- MAX_ITER, 2, maximum number of descent iterations (phase A + phase B) per pattern; must be >= 1.
- CLK  in  1  clock, all logic on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- IN_VALID  in  1  X/Y carry a point this cycle.
- X, Y  in  COORD_W  point coordinates.
- C1X, C1Y, C2X, C2Y  out  COORD_W  result centres.
- COVER  out  $clog2(NUM_PTS+1)  points covered by the result.
- DONE  out  1  one-cycle pulse: result valid.

## Operation
- Reset: all outputs are 0. FSM goes to LOAD. Point count, working centres and best-so-far cover are cleared to 0. Working centres WC1 and WC2 reset to (0,0).
- LOAD:
  - Each cycle with IN_VALID=1 writes (X,Y) to point slot idx and increments idx. Cycles with IN_VALID=0 are ignored.
  - Accepting point NUM_PTS-1 moves the FSM to SCAN_A. IN_VALID is ignored in every other state.
- SCAN_A (WC2 fixed):
  - Candidates (cx,cy) are visited in raster order, cy outer and cx inner, each from 0 to 2^COORD_W-1.
  - Each candidate takes NUM_PTS cycles, one point per cycle, i = 0..NUM_PTS-1.
  - The accumulator adds 1 when in(cand,p_i) or in(WC2,p_i).
- Accumulator and candidate selection:
  - The accumulator is registered and cleared at each candidate start.
  - At the candidate's last point, the final count (including that point) is compared with best. Only a strictly greater count replaces best and bestpos, so ties keep the earliest raster candidate.
  - best resets to 0 at phase start; bestpos resets to the current WC1.
  - At the end of the phase, WC1 <= bestpos.
- SCAN_B: identical to SCAN_A, with the roles swapped (WC1 fixed, WC2 updated). The final best of SCAN_B is the iteration cover.
- CHECK (1 cycle):
  - If the iteration cover equals prev_cover (0 before the first iteration), or the iteration count equals MAX_ITER: C1/C2/COVER <= WC1/WC2/cover, DONE pulses, and the FSM returns to LOAD with idx=0.
  - Otherwise prev_cover <= cover and the FSM goes to SCAN_A.
- Working centres persist into the next pattern; they are not reset on LOAD. C1/C2/COVER change only in the DONE cycle and hold until the next DONE or reset.
- Distance arithmetic:
  - dx and dy are unsigned absolute differences, COORD_W bits each.
  - dx²+dy² is computed at 2*COORD_W+1 bits with no truncation and compared against the constant RADIUS², also at 2*COORD_W+1 bits.
  - Duplicate points count separately.

## Timing
- P = 2^(2*COORD_W) * NUM_PTS cycles per phase. With defaults P = 10240.
- Let e0 be the rising edge that accepts the last point. SCAN_A's first point is evaluated in the cycle after e0.
- Each iteration lasts 2P+1 cycles (2P scanning plus CHECK). DONE is high in the cycle after edge e0 + n*(2P+1), where n is the number of iterations executed.
- With defaults, the worst case is e0 + 40962.
- DONE is high for exactly one cycle. The next pattern's points may arrive starting the cycle DONE is high.
- Asynchronous RST_N assertion at any point (mid-load, mid-scan, or in the DONE cycle) immediately forces reset values. A partial pattern is discarded.

## Test plan
- Two clusters, defaults: 20×(2,2) then 20×(12,12), IN_VALID held high -> iteration 1 gives WC1=(12,8), WC2=(0,0), cover 40; iteration 2 repeats it. DONE at e0+40962 with C1=(12,8), C2=(0,0), COVER=40.
- Single cluster: 40×(7,7) -> C1=(7,3), C2=(0,0), COVER=40, DONE at e0+40962.
- IN_VALID gaps: same two-cluster data with IN_VALID low on every other cycle -> identical result. The DONE offset is measured from the edge accepting the last point.
- Back-to-back: two-cluster pattern, then 40×(15,15) starting in the DONE cycle.
  - The second search starts from WC1=(12,8), WC2=(0,0).
  - Iteration 1: WC1=(15,11), cover 40. Iteration 2 equal -> DONE with C1=(15,11), C2=(0,0), COVER=40.
  - Outputs hold the first result until the second DONE.
- Reset mid-scan: drop RST_N low 5000 cycles after e0 -> all outputs 0 at once and no DONE. Reloading the two-cluster pattern reproduces the first-test result and timing.
- Parameter sweep: COORD_W=3, NUM_PTS=8, RADIUS=2, points 4×(1,1) and 4×(6,6) -> C1=(6,4), C2=(0,0), COVER=8.
  - P=512; DONE at e0+2*(1025)=e0+2050.
